hazard_controller: RTL and testbench
====================================

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 clock  in  1  single clock; all state on rising edge.
REQ-002 reset_n  in  1  asynchronous, active-low reset.
REQ-003 issue_valid  in  1  stage 1 presents an instruction for issue this cycle.
REQ-004 issue_dest_write  in  1  issuing instruction writes a register (LOADI, LOAD, ALU, ALUM).
REQ-005 issue_dest_index  in  4  destination register of issuing instruction.
REQ-006 issue_src_a_used / issue_src_b_used  in  1 each  source operand read by issuing instruction.
REQ-007 issue_src_a_index / issue_src_b_index  in  4 each  source register indices.
REQ-008 retire_write  in  1  stage 2 write or write_immediate strobe, OR'd.
REQ-009 retire_index  in  4  stage 2 write_index.
REQ-010 flush  in  1  discard all in-flight writes.
REQ-011 halting  in  1  halt request.
REQ-012 stall  out  1  hold stage 1; instruction not issued this cycle.
REQ-013 issue_accept  out  1  issue_valid && !stall.
REQ-014 pending  out  16  bit n = register n has nonzero pending count.
REQ-015 halted  out  1  pipeline drained, halt complete.
REQ-016 underflow_error  out  1  sticky: retire seen with zero pending count.
REQ-017 state  out  2  t_hazard_state, for debug.

Function
REQ-018 Per register: 2-bit pending count, 0..3.
REQ-019 Count increments on issue_accept && issue_dest_write for issue_dest_index.
REQ-020 Count decrements on retire_write for retire_index.
REQ-021 Increment and decrement of the same register in one cycle: count unchanged.
REQ-022 Retire with count 0: count stays 0; underflow_error sets, held until reset.
REQ-023 stall is combinational; asserted in RUN if any of:
- issue_valid and a used source has count > 0;
- issue_dest_write and dest count == 3.
REQ-024 Same-cycle retire of a source register does not clear that source's stall; it is evaluated on registered counts.
REQ-025 Unused source indices never cause stall.
REQ-026 States: RUN, DRAIN, HALTED, FLUSH.
REQ-027 RUN -> FLUSH on flush.
REQ-028 RUN -> DRAIN on halting, flush not asserted.
REQ-029 FLUSH: all counts zeroed in one cycle; stall=1; next state RUN, or DRAIN if halting is asserted.
REQ-030 DRAIN: stall=1; retires still decrement; -> HALTED when all counts are zero.
REQ-031 HALTED: stall=1, halted=1; absorbing until reset; flush ignored.
REQ-032 Flush has priority over halting and retire in every state except HALTED.
REQ-033 Latency: count change is visible on pending and stall the cycle after the event.

Reset
REQ-034 reset_n low: all counts 0, state RUN, pending 0, halted 0, underflow_error 0, stall 0.
REQ-035 reset_n low mid-DRAIN or mid-FLUSH returns to RUN with cleared counts; no residual error.

Structure
REQ-036 t_hazard_state enum goes in new shared header hazard.vh.
REQ-037 REG_COUNT (16) goes in registers.vh.
REQ-038 One sub-module, hazard_counter: a single 2-bit up/down counter with clear, underflow flag and nonzero output; instantiated 16 times.

Verification
REQ-039 Issue r3 write, then next cycle issue with src_a=r3 -> stall=1 until the r3 retire; stall=0 the cycle after the retire.
REQ-040 Three issues to r5 with no retire, then a fourth -> stall=1 on the fourth; one r5 retire -> fourth accepted the next cycle.
REQ-041 Issue r7 and retire r7 in the same cycle with count 1 -> count stays 1; pending[7]=1.
REQ-042 Retire r2 with count 0 -> underflow_error=1 and stays 1 through 10 idle cycles; pending[2]=0.
REQ-043 Counts r1=2, r4=1; assert halting -> DRAIN; three retires -> halted=1 the cycle after the last retire; stall held 1 throughout.
REQ-044 Counts nonzero; assert flush and halting together -> FLUSH, pending=0 the next cycle, then DRAIN, then HALTED; reset_n low -> RUN, all outputs 0.

Source files
------------

// File: rtl/hazard_controller_pkg.sv
// Shared types and sizing for the register hazard (scoreboard) controller.
package hazard_controller_pkg;

    localparam int REG_COUNT = 16;
    localparam int REG_IDX_W = 4;
    localparam int CNT_W     = 2;

    localparam logic [CNT_W-1:0] CNT_MAX = 2'd3;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2,
        FLUSH  = 2'd3
    } t_hazard_state;

endpackage

// File: rtl/hazard_controller_counter.sv
// One register's in-flight write count: saturating 2-bit up/down counter with
// clear, a sticky underflow flag and a look-ahead "will be zero" output.
module hazard_counter
    import hazard_controller_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_clear,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count,
    output logic             o_nonzero,
    output logic             o_underflow,
    output logic             o_nextZero
);

    logic [CNT_W-1:0] r_count;
    logic             r_underflow;
    logic [CNT_W-1:0] w_nextCount;
    logic             w_underflowEvent;

    // Simultaneous inc and dec cancel; clear wins over both.
    always_comb begin
        w_nextCount      = r_count;
        w_underflowEvent = 1'b0;
        if (i_clear) begin
            w_nextCount = '0;
        end else if (i_inc && !i_dec) begin
            if (r_count != CNT_MAX) begin
                w_nextCount = r_count + 1'b1;
            end
        end else if (i_dec && !i_inc) begin
            if (r_count == '0) begin
                w_underflowEvent = 1'b1;
            end else begin
                w_nextCount = r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count     <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_count <= w_nextCount;
            if (w_underflowEvent) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign o_count     = r_count;
    assign o_nonzero   = (r_count != '0);
    assign o_underflow = r_underflow;
    assign o_nextZero  = (w_nextCount == '0);

endmodule

// File: rtl/hazard_controller.sv
// Register scoreboard: stalls issue on RAW hazards or a full per-register
// count, and sequences flush and halt/drain of in-flight writes.
module hazard_controller
    import hazard_controller_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 issue_valid,
    input  logic                 issue_dest_write,
    input  logic [REG_IDX_W-1:0] issue_dest_index,
    input  logic                 issue_src_a_used,
    input  logic [REG_IDX_W-1:0] issue_src_a_index,
    input  logic                 issue_src_b_used,
    input  logic [REG_IDX_W-1:0] issue_src_b_index,
    input  logic                 retire_write,
    input  logic [REG_IDX_W-1:0] retire_index,
    input  logic                 flush,
    input  logic                 halting,
    output logic                 stall,
    output logic                 issue_accept,
    output logic [REG_COUNT-1:0] pending,
    output logic                 halted,
    output logic                 underflow_error,
    output logic [1:0]           state
);

    t_hazard_state        r_state;
    logic                 r_halted;
    logic                 w_stall;
    logic                 w_clear;
    logic                 w_issueWrite;
    logic                 w_srcHazard;
    logic                 w_destFull;
    logic [CNT_W-1:0]     w_count [REG_COUNT];
    logic [REG_COUNT-1:0] w_underflow;
    logic [REG_COUNT-1:0] w_nextZero;

    // Hazards are judged on registered counts only, so a same-cycle retire
    // of a source does not release the stall until the following cycle.
    always_comb begin
        w_srcHazard = (issue_src_a_used && (w_count[issue_src_a_index] != '0)) ||
                      (issue_src_b_used && (w_count[issue_src_b_index] != '0));
        w_destFull  = issue_dest_write && (w_count[issue_dest_index] == CNT_MAX);
        w_stall     = 1'b1;
        if (r_state == RUN) begin
            w_stall = (issue_valid && w_srcHazard) || w_destFull;
        end
    end

    assign w_issueWrite = issue_valid && !w_stall && issue_dest_write;
    assign w_clear      = (r_state == FLUSH) || (flush && (r_state != HALTED));

    for (genvar n = 0; n < REG_COUNT; n++) begin : g_counter
        hazard_counter u_counter (
            .clock       (clock),
            .reset_n     (reset_n),
            .i_clear     (w_clear),
            .i_inc       (w_issueWrite && (issue_dest_index == REG_IDX_W'(n))),
            .i_dec       (retire_write && (retire_index == REG_IDX_W'(n))),
            .o_count     (w_count[n]),
            .o_nonzero   (pending[n]),
            .o_underflow (w_underflow[n]),
            .o_nextZero  (w_nextZero[n])
        );
    end

    // DRAIN looks at next-cycle counts so halted rises right after the last retire.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= RUN;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (flush) begin
                        r_state <= FLUSH;
                    end else if (halting) begin
                        r_state <= DRAIN;
                    end
                end
                FLUSH: begin
                    if (flush) begin
                        r_state <= FLUSH;
                    end else if (halting) begin
                        r_state <= DRAIN;
                    end else begin
                        r_state <= RUN;
                    end
                end
                DRAIN: begin
                    if (flush) begin
                        r_state <= FLUSH;
                    end else if (&w_nextZero) begin
                        r_state  <= HALTED;
                        r_halted <= 1'b1;
                    end
                end
                HALTED: begin
                    r_state  <= HALTED;
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state  <= RUN;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign stall           = w_stall;
    assign issue_accept    = issue_valid && !w_stall;
    assign halted          = r_halted;
    assign underflow_error = |w_underflow;
    assign state           = r_state;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller: hazards, saturation,
// underflow, drain/halt, flush and reset recovery.
module tb_hazard_controller;

    logic        clock;
    logic        reset_n;
    logic        issue_valid;
    logic        issue_dest_write;
    logic [3:0]  issue_dest_index;
    logic        issue_src_a_used;
    logic [3:0]  issue_src_a_index;
    logic        issue_src_b_used;
    logic [3:0]  issue_src_b_index;
    logic        retire_write;
    logic [3:0]  retire_index;
    logic        flush;
    logic        halting;
    logic        stall;
    logic        issue_accept;
    logic [15:0] pending;
    logic        halted;
    logic        underflow_error;
    logic [1:0]  state;

    int checkCount = 0;
    int errorCount = 0;

    hazard_controller dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .issue_valid       (issue_valid),
        .issue_dest_write  (issue_dest_write),
        .issue_dest_index  (issue_dest_index),
        .issue_src_a_used  (issue_src_a_used),
        .issue_src_a_index (issue_src_a_index),
        .issue_src_b_used  (issue_src_b_used),
        .issue_src_b_index (issue_src_b_index),
        .retire_write      (retire_write),
        .retire_index      (retire_index),
        .flush             (flush),
        .halting           (halting),
        .stall             (stall),
        .issue_accept      (issue_accept),
        .pending           (pending),
        .halted            (halted),
        .underflow_error   (underflow_error),
        .state             (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic destWrite, input logic [3:0] dest,
                                 input logic aUsed, input logic [3:0] a,
                                 input logic bUsed, input logic [3:0] b,
                                 input logic retWrite, input logic [3:0] retIdx,
                                 input logic flushIn, input logic haltIn);
        issue_valid       = valid;
        issue_dest_write  = destWrite;
        issue_dest_index  = dest;
        issue_src_a_used  = aUsed;
        issue_src_a_index = a;
        issue_src_b_used  = bUsed;
        issue_src_b_index = b;
        retire_write      = retWrite;
        retire_index      = retIdx;
        flush             = flushIn;
        halting           = haltIn;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic issueTo(input logic [3:0] dest);
        applyStimulus(1, 1, dest, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic retireFrom(input logic [3:0] idx);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, idx, 0, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        idle();
        tick();
        checkOutput("reset_state", 32'(state), 32'd0);
        checkOutput("reset_pending", 32'(pending), 32'h0);
        checkOutput("reset_halted", 32'(halted), 32'd0);
        checkOutput("reset_underflow", 32'(underflow_error), 32'd0);
        checkOutput("reset_stall", 32'(stall), 32'd0);
        reset_n = 1'b1;
        tick();

        // RAW hazard on r3 held until the cycle after its retire.
        issueTo(3);
        checkOutput("r3_issue_stall", 32'(stall), 32'd0);
        checkOutput("r3_issue_accept", 32'(issue_accept), 32'd1);
        tick();
        checkOutput("r3_pending", 32'(pending), 32'h0008);
        applyStimulus(1, 1, 6, 1, 3, 0, 0, 0, 0, 0, 0);
        checkOutput("raw_stall_c1", 32'(stall), 32'd1);
        checkOutput("raw_accept_c1", 32'(issue_accept), 32'd0);
        tick();
        checkOutput("raw_stall_c2", 32'(stall), 32'd1);
        applyStimulus(1, 1, 6, 1, 3, 0, 0, 1, 3, 0, 0);
        checkOutput("raw_stall_same_cycle_retire", 32'(stall), 32'd1);
        tick();
        applyStimulus(1, 1, 6, 1, 3, 0, 0, 0, 0, 0, 0);
        checkOutput("raw_stall_after_retire", 32'(stall), 32'd0);
        checkOutput("raw_accept_after_retire", 32'(issue_accept), 32'd1);
        tick();
        checkOutput("r6_pending", 32'(pending), 32'h0040);
        retireFrom(6);
        tick();
        checkOutput("r6_retired", 32'(pending), 32'h0);

        // Saturation: three writes in flight to r5 block a fourth.
        for (int i = 0; i < 3; i++) begin
            issueTo(5);
            checkOutput("r5_fill_accept", 32'(issue_accept), 32'd1);
            tick();
        end
        checkOutput("r5_pending_full", 32'(pending), 32'h0020);
        applyStimulus(1, 1, 5, 0, 0, 0, 0, 1, 5, 0, 0);
        checkOutput("r5_fourth_stall", 32'(stall), 32'd1);
        checkOutput("r5_fourth_accept", 32'(issue_accept), 32'd0);
        tick();
        issueTo(5);
        checkOutput("r5_fourth_retry_stall", 32'(stall), 32'd0);
        checkOutput("r5_fourth_retry_accept", 32'(issue_accept), 32'd1);
        tick();
        applyStimulus(1, 0, 5, 0, 5, 0, 5, 0, 0, 0, 0);
        checkOutput("unused_src_no_stall", 32'(stall), 32'd0);
        applyStimulus(1, 0, 0, 0, 5, 1, 5, 0, 0, 0, 0);
        checkOutput("used_src_b_stall", 32'(stall), 32'd1);
        applyStimulus(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("r5_full_again_stall", 32'(stall), 32'd1);
        for (int i = 0; i < 3; i++) begin
            retireFrom(5);
            tick();
        end
        checkOutput("r5_drained", 32'(pending), 32'h0);

        // Same-cycle issue and retire of r7 leaves its count unchanged.
        issueTo(7);
        tick();
        applyStimulus(1, 1, 7, 0, 0, 0, 0, 1, 7, 0, 0);
        checkOutput("r7_both_accept", 32'(issue_accept), 32'd1);
        tick();
        checkOutput("r7_pending_kept", 32'(pending), 32'h0080);
        retireFrom(7);
        tick();
        checkOutput("r7_cleared", 32'(pending), 32'h0);
        checkOutput("no_underflow_yet", 32'(underflow_error), 32'd0);

        // Retire with nothing pending: sticky underflow.
        retireFrom(2);
        tick();
        checkOutput("underflow_set", 32'(underflow_error), 32'd1);
        checkOutput("underflow_pending", 32'(pending), 32'h0);
        idle();
        for (int i = 0; i < 10; i++) tick();
        checkOutput("underflow_sticky", 32'(underflow_error), 32'd1);
        checkOutput("underflow_r2_clear", 32'(pending[2]), 32'd0);

        // Drain to halt with r1=2, r4=1.
        issueTo(1);
        tick();
        issueTo(1);
        tick();
        issueTo(4);
        tick();
        checkOutput("drain_pending", 32'(pending), 32'h0012);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("halt_req_state", 32'(state), 32'd0);
        checkOutput("halt_req_stall", 32'(stall), 32'd0);
        tick();
        checkOutput("drain_state", 32'(state), 32'd1);
        applyStimulus(1, 1, 8, 0, 0, 0, 0, 1, 1, 0, 1);
        checkOutput("drain_stall_1", 32'(stall), 32'd1);
        checkOutput("drain_accept", 32'(issue_accept), 32'd0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
        checkOutput("drain_stall_2", 32'(stall), 32'd1);
        checkOutput("drain_state_2", 32'(state), 32'd1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 1);
        checkOutput("drain_not_halted", 32'(halted), 32'd0);
        checkOutput("drain_stall_3", 32'(stall), 32'd1);
        tick();
        checkOutput("halted_set", 32'(halted), 32'd1);
        checkOutput("halted_state", 32'(state), 32'd2);
        checkOutput("halted_stall", 32'(stall), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        checkOutput("halted_ignores_flush", 32'(state), 32'd2);
        checkOutput("halted_stays", 32'(halted), 32'd1);
        reset_n = 1'b0;
        idle();
        checkOutput("halt_reset_state", 32'(state), 32'd0);
        checkOutput("halt_reset_halted", 32'(halted), 32'd0);
        checkOutput("halt_reset_underflow", 32'(underflow_error), 32'd0);
        reset_n = 1'b1;
        tick();

        // Flush and halt together: FLUSH, DRAIN, HALTED.
        issueTo(9);
        tick();
        issueTo(9);
        tick();
        issueTo(2);
        tick();
        checkOutput("flush_pre_pending", 32'(pending), 32'h0204);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        tick();
        checkOutput("flush_state", 32'(state), 32'd3);
        checkOutput("flush_pending", 32'(pending), 32'h0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("flush_stall", 32'(stall), 32'd1);
        checkOutput("flush_accept", 32'(issue_accept), 32'd0);
        tick();
        checkOutput("flush_to_drain", 32'(state), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        checkOutput("flush_halted_state", 32'(state), 32'd2);
        checkOutput("flush_halted", 32'(halted), 32'd1);
        reset_n = 1'b0;
        idle();
        checkOutput("post_halt_reset_state", 32'(state), 32'd0);
        checkOutput("post_halt_reset_pending", 32'(pending), 32'h0);
        checkOutput("post_halt_reset_halted", 32'(halted), 32'd0);
        checkOutput("post_halt_reset_underflow", 32'(underflow_error), 32'd0);
        checkOutput("post_halt_reset_stall", 32'(stall), 32'd0);
        checkOutput("post_halt_reset_accept", 32'(issue_accept), 32'd0);
        reset_n = 1'b1;
        tick();

        // Reset taken mid-FLUSH and mid-DRAIN.
        issueTo(0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        checkOutput("mid_flush_state", 32'(state), 32'd3);
        reset_n = 1'b0;
        idle();
        checkOutput("mid_flush_reset_state", 32'(state), 32'd0);
        reset_n = 1'b1;
        tick();
        issueTo(0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        checkOutput("mid_drain_state", 32'(state), 32'd1);
        checkOutput("mid_drain_pending", 32'(pending), 32'h0001);
        reset_n = 1'b0;
        idle();
        checkOutput("mid_drain_reset_state", 32'(state), 32'd0);
        checkOutput("mid_drain_reset_pending", 32'(pending), 32'h0);
        reset_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
